// File: rtl/mem_region_ctrl.sv
// Two-port (fetch/data) controller onto IMEM, ROM and RAM regions with per-region wait states.
// Optional sticky fault capture is compiled in when MEMCTRL_FAULT_EN is defined.
module mem_region_ctrl #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned IMEM_BASE = 0,
  parameter int unsigned IMEM_SIZE = 400,
  parameter int unsigned ROM_BASE  = 400,
  parameter int unsigned ROM_SIZE  = 8100,
  parameter int unsigned RAM_BASE  = 8500,
  parameter int unsigned RAM_SIZE  = 129600,
  parameter int unsigned IMEM_WAIT = 0,
  parameter int unsigned ROM_WAIT  = 1,
  parameter int unsigned RAM_WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic [1:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] imem_rdata,
  input  logic [DW-1:0] rom_rdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          fault,
  output logic [AW-1:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_IMEM = 2'd1;
  localparam logic [1:0] SEL_ROM  = 2'd2;
  localparam logic [1:0] SEL_RAM  = 2'd3;

  localparam logic [AW:0] IMEM_LO = (AW+1)'(IMEM_BASE);
  localparam logic [AW:0] IMEM_SZ = (AW+1)'(IMEM_SIZE);
  localparam logic [AW:0] ROM_LO  = (AW+1)'(ROM_BASE);
  localparam logic [AW:0] ROM_SZ  = (AW+1)'(ROM_SIZE);
  localparam logic [AW:0] RAM_LO  = (AW+1)'(RAM_BASE);
  localparam logic [AW:0] RAM_SZ  = (AW+1)'(RAM_SIZE);

  state_t        r_state;
  logic [3:0]    r_wcnt;
  logic          r_last_data;
  logic          r_port_data;
  logic          r_we;
  logic          r_i_valid;
  logic [DW-1:0] r_i_rdata;
  logic          r_d_valid;
  logic [DW-1:0] r_d_rdata;
  logic [1:0]    r_mem_sel;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_wdata;
  logic          r_busy;

  logic          w_any;
  logic          w_grant_data;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_addr_x;
  logic [AW:0]   w_imem_off;
  logic [AW:0]   w_rom_off;
  logic [AW:0]   w_ram_off;
  logic [1:0]    w_region;
  logic [3:0]    w_wait;
  logic [AW-1:0] w_offset;
  logic [DW-1:0] w_resp_rdata;

  // With both ports pending the one not served last wins; r_last_data resets to "fetch" so data wins first.
  assign w_any        = i_req | d_req;
  assign w_grant_data = d_req & (~i_req | ~r_last_data);
  assign w_addr       = w_grant_data ? d_addr : i_addr;
  assign w_we         = w_grant_data & d_we;
  assign w_addr_x     = {1'b0, w_addr};

  // One unsigned compare per region: below BASE the AW+1-bit difference lands >= 2**AW, above any SIZE.
  assign w_imem_off = w_addr_x - IMEM_LO;
  assign w_rom_off  = w_addr_x - ROM_LO;
  assign w_ram_off  = w_addr_x - RAM_LO;

  always_comb begin
    w_region = SEL_NONE;
    w_wait   = 4'd0;
    w_offset = '0;
    if (w_imem_off < IMEM_SZ) begin
      w_region = SEL_IMEM;
      w_wait   = 4'(IMEM_WAIT);
      w_offset = w_imem_off[AW-1:0];
    end else if (w_rom_off < ROM_SZ) begin
      w_region = SEL_ROM;
      w_wait   = 4'(ROM_WAIT);
      w_offset = w_rom_off[AW-1:0];
    end else if (w_ram_off < RAM_SZ) begin
      w_region = SEL_RAM;
      w_wait   = 4'(RAM_WAIT);
      w_offset = w_ram_off[AW-1:0];
    end
  end

  // Writes outside RAM and fetches outside IMEM complete with zero data.
  always_comb begin
    w_resp_rdata = '0;
    case (r_mem_sel)
      SEL_IMEM: w_resp_rdata = imem_rdata;
      SEL_ROM:  w_resp_rdata = rom_rdata;
      SEL_RAM:  w_resp_rdata = ram_rdata;
      default:  w_resp_rdata = '0;
    endcase
    if (r_we && (r_mem_sel != SEL_RAM)) begin
      w_resp_rdata = '0;
    end
    if (!r_port_data && (r_mem_sel != SEL_IMEM)) begin
      w_resp_rdata = '0;
    end
  end

`ifdef MEMCTRL_FAULT_EN
  logic          r_fault;
  logic [AW-1:0] r_fault_addr;
  logic          w_fault_evt;

  assign w_fault_evt = (w_region == SEL_NONE)
                     | (w_we & ((w_region == SEL_IMEM) | (w_region == SEL_ROM)))
                     | (~w_grant_data & (w_region != SEL_IMEM));
  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`else
  assign fault      = 1'b0;
  assign fault_addr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wcnt      <= 4'd0;
      r_last_data <= 1'b0;
      r_port_data <= 1'b0;
      r_we        <= 1'b0;
      r_i_valid   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_d_rdata   <= '0;
      r_mem_sel   <= SEL_NONE;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
`ifdef MEMCTRL_FAULT_EN
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ACCESS;
            r_wcnt      <= w_wait;
            r_port_data <= w_grant_data;
            r_last_data <= w_grant_data;
            r_we        <= w_we;
            r_mem_sel   <= w_region;
            r_mem_addr  <= (w_region == SEL_NONE) ? '0 : w_offset;
            r_mem_wdata <= w_we ? d_wdata : '0;
            // A zero-wait RAM write has a single ACCESS cycle, so the strobe starts right away.
            r_mem_we    <= w_we && (w_region == SEL_RAM) && (w_wait == 4'd0);
            r_busy      <= 1'b1;
`ifdef MEMCTRL_FAULT_EN
            if (w_fault_evt && !r_fault) begin
              r_fault      <= 1'b1;
              r_fault_addr <= w_addr;
            end
`endif
          end
        end
        ACCESS: begin
          if (r_wcnt == 4'd0) begin
            r_state     <= RESP;
            r_mem_sel   <= SEL_NONE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            if (r_port_data) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= w_resp_rdata;
            end else begin
              r_i_valid <= 1'b1;
              r_i_rdata <= w_resp_rdata;
            end
          end else begin
            r_wcnt   <= r_wcnt - 4'd1;
            r_mem_we <= r_we && (r_mem_sel == SEL_RAM) && (r_wcnt == 4'd1);
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_i_valid <= 1'b0;
          r_d_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i_valid   = r_i_valid;
  assign i_rdata   = r_i_rdata;
  assign d_valid   = r_d_valid;
  assign d_rdata   = r_d_rdata;
  assign mem_sel   = r_mem_sel;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Randomized bench for mem_region_ctrl against an address-map/arbitration reference model.
// Fault expectations follow MEMCTRL_FAULT_EN when the bench is built with it.
module tb_mem_region_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic [1:0]  mem_sel;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] rom_rdata;
  logic [31:0] ram_rdata;
  logic        busy;
  logic        fault;
  logic [31:0] fault_addr;

  always #5 clk = ~clk;

  mem_region_ctrl dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .imem_rdata(imem_rdata), .rom_rdata(rom_rdata), .ram_rdata(ram_rdata),
    .busy(busy), .fault(fault), .fault_addr(fault_addr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_last_data;
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  bit          m_fault;
  logic [31:0] m_fault_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    longint x;
    x = longint'(a);
    if (x >= 0 && x < 400) return 1;
    if (x >= 400 && x < 8500) return 2;
    if (x >= 8500 && x < 138100) return 3;
    return 0;
  endfunction

  function automatic int wait_of(input int r);
    case (r)
      2: return 1;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic longint base_of(input int r);
    case (r)
      2: return 400;
      3: return 8500;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1: return $urandom_range(0, 399);
      2, 3: return $urandom_range(400, 8499);
      4, 5: return $urandom_range(8500, 138099);
      6: return $urandom_range(138100, 1000000);
      7: return $urandom;
      default: begin
        case ($urandom_range(0, 7))
          0: return 32'd0;
          1: return 32'd399;
          2: return 32'd400;
          3: return 32'd8499;
          4: return 32'd8500;
          5: return 32'd138099;
          6: return 32'd138100;
          default: return 32'hFFFF_FFFF;
        endcase
      end
    endcase
  endfunction

  task automatic check_fault_outputs();
`ifdef MEMCTRL_FAULT_EN
    check_eq("fault", fault, m_fault);
    check_eq("fault_addr", fault_addr, m_fault_addr);
`else
    check_eq("fault", fault, 0);
    check_eq("fault_addr", fault_addr, 0);
`endif
  endtask

  // Called at the negedge of the IDLE cycle in which the request is sampled.
  task automatic watch(input bit is_data, input logic [31:0] addr, input bit we, input logic [31:0] wdata);
    int          r;
    int          w;
    int          we_cnt;
    bit          got;
    bit          exp_strobe;
    logic [31:0] exp_rd;
    r          = region_of(addr);
    w          = wait_of(r);
    we_cnt     = 0;
    got        = 1'b0;
    exp_strobe = is_data && we && (r == 3);
    if (is_data && we && r != 3) exp_rd = 32'd0;
    else if (!is_data && r != 1) exp_rd = 32'd0;
    else if (r == 1) exp_rd = imem_rdata;
    else if (r == 2) exp_rd = rom_rdata;
    else if (r == 3) exp_rd = ram_rdata;
    else exp_rd = 32'd0;
    if (!m_fault && ((r == 0) || (is_data && we && (r == 1 || r == 2)) || (!is_data && r != 1))) begin
      m_fault      = 1'b1;
      m_fault_addr = addr;
    end
    m_last_data = is_data;
    if (is_data) m_d_rdata = exp_rd;
    else m_i_rdata = exp_rd;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_eq("busy_access", busy, 1);
        check_eq("mem_sel", mem_sel, r);
        if (r != 0) check_eq("mem_addr", mem_addr, longint'(addr) - base_of(r));
      end
      if (mem_we) begin
        we_cnt++;
        check_eq("we_cycle", k, w + 1);
        check_eq("we_addr", mem_addr, longint'(addr) - base_of(r));
        check_eq("we_wdata", mem_wdata, wdata);
      end
      if (i_valid || d_valid) begin
        got = 1'b1;
        $display("[TB] %s addr=%0d we=%0b region=%0d latency=%0d", is_data ? "data " : "fetch", addr, we, r, k);
        check_eq("latency", k, w + 2);
        check_eq("valid_port", {i_valid, d_valid}, is_data ? 2'b01 : 2'b10);
        check_eq("i_rdata", i_rdata, m_i_rdata);
        check_eq("d_rdata", d_rdata, m_d_rdata);
        check_eq("sel_resp", {mem_sel, mem_we}, 0);
        check_fault_outputs();
        if (is_data) d_req = 1'b0;
        else i_req = 1'b0;
      end
    end
    if (!got) check_eq("timeout", 0, 1);
    check_eq("we_count", we_cnt, exp_strobe);
  endtask

  task automatic txn(input bit ui, input bit ud, input logic [31:0] ai, input logic [31:0] ad,
                     input bit we, input logic [31:0] wd);
    bit first_data;
    @(negedge clk);
    check_eq("idle_valid", {i_valid, d_valid, busy}, 0);
    imem_rdata = $urandom;
    rom_rdata  = $urandom;
    ram_rdata  = $urandom;
    i_req   = ui;
    i_addr  = ai;
    d_req   = ud;
    d_we    = we;
    d_addr  = ad;
    d_wdata = wd;
    first_data = ud && (!ui || !m_last_data);
    if (first_data) watch(1'b1, ad, we, wd);
    else watch(1'b0, ai, 1'b0, 32'd0);
    if (ui && ud) begin
      @(negedge clk);
      check_eq("gap_valid", {i_valid, d_valid}, 0);
      if (first_data) watch(1'b0, ai, 1'b0, 32'd0);
      else watch(1'b1, ad, we, wd);
    end
  endtask

  task automatic model_reset();
    m_last_data  = 1'b0;
    m_i_rdata    = 32'd0;
    m_d_rdata    = 32'd0;
    m_fault      = 1'b0;
    m_fault_addr = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {i_valid, d_valid, busy, mem_we, mem_sel}, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_wdata"}, mem_wdata, 0);
    check_eq({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    check_eq({tag, "_fault"}, {fault, fault_addr}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    imem_rdata = '0; rom_rdata = '0; ram_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Both ports from reset: data (ROM 400) first, then fetch 8
    txn(1'b1, 1'b1, 32'd8, 32'd400, 1'b0, 32'd0);
    txn(1'b0, 1'b1, 32'd0, 32'd8504, 1'b1, 32'hDEAD_BEEF);
    txn(1'b1, 1'b1, 32'd12, 32'd9000, 1'b0, 32'd0);
    txn(1'b0, 1'b1, 32'd0, 32'd200000, 1'b0, 32'd0);
    txn(1'b0, 1'b1, 32'd0, 32'd300000, 1'b0, 32'd0);

    for (int n = 0; n < 150; n++) begin
      bit ui;
      bit ud;
      ui = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      if (!ui && !ud) ud = 1'b1;
      txn(ui, ud, pick_addr(), pick_addr(), ($urandom_range(0, 2) == 0), $urandom);
    end

    // Reset in the middle of a RAM write: no strobe, no valid, everything zero
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8504; d_wdata = 32'hDEAD_BEEF; i_req = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_sel", mem_sel, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_abort");
    d_req = 1'b0; d_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rst_hold", {mem_we, i_valid, d_valid, busy}, 0);
    end
    rst = 1'b0;
    model_reset();

    for (int n = 0; n < 20; n++) begin
      txn(1'b1, 1'b1, pick_addr(), pick_addr(), ($urandom_range(0, 1) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_region_ctrl.md
MEM_REGION_CTRL -- requirements
Module: mem_region_ctrl

Interface
REQ-001 Parameters SHALL be name, default, meaning, one per line:
- AW, 32, address width.
- DW, 32, data width.
- IMEM_BASE, 0, instruction-region base.
- IMEM_SIZE, 400, instruction-region size.
- ROM_BASE, 400, data-ROM base.
- ROM_SIZE, 8100, data-ROM size.
- RAM_BASE, 8500, data-RAM base.
- RAM_SIZE, 129600, data-RAM size.
- IMEM_WAIT, 0, wait states for the instruction region.
- ROM_WAIT, 1, wait states for ROM.
- RAM_WAIT, 2, wait states for RAM; all wait parameters are 0..15.
REQ-002 Ports SHALL be name, direction, width, meaning, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_valid.
- i_addr  in  AW  fetch address (pc).
- i_valid  out  1  one-cycle fetch completion.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  data write.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_valid  out  1  one-cycle data completion.
- d_rdata  out  DW  read data.
- mem_sel  out  2  0=none, 1=IMEM, 2=ROM, 3=RAM.
- mem_addr  out  AW  region-relative offset.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  DW  RAM write data.
- imem_rdata, rom_rdata, ram_rdata  in  DW each  region read data.
- busy  out  1  access in flight.
- fault  out  1  sticky fault flag.
- fault_addr  out  AW  first faulting address.

Function
REQ-003 Region match SHALL be half-open: BASE <= addr < BASE+SIZE, computed at AW+1 bits with no wrap; an address outside all regions SHALL be unmapped.
REQ-004 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-005 In IDLE with any request pending, the block SHALL latch port, address, we and wdata, decode the region, load wcnt with that region's WAIT (0 if unmapped), and go to ACCESS.
REQ-006 Arbitration: with both requests pending, the port not served last SHALL win; after reset, data wins.
REQ-007 In ACCESS, mem_sel and mem_addr (addr minus BASE) SHALL be driven from latched values; wcnt SHALL decrement each cycle.
REQ-008 When wcnt==0, the block SHALL register the selected rdata (0 if unmapped) and go to RESP.
REQ-009 In RESP, the served port's valid SHALL be high for exactly one cycle with its rdata; the FSM SHALL then return to IDLE.
REQ-010 Latency from request sampled in IDLE to valid SHALL be WAIT+2 cycles; throughput SHALL be one access per WAIT+3 cycles.
REQ-011 mem_we SHALL pulse exactly once, in the final ACCESS cycle, only for a data write to RAM; writes to IMEM, ROM or unmapped space SHALL produce no strobe and d_valid with d_rdata=0.
REQ-012 i_rdata and d_rdata SHALL hold their last value between completions.
REQ-013 busy SHALL be high in ACCESS and RESP.
REQ-014 Outside ACCESS, mem_sel SHALL be 0, and mem_we SHALL be 0.
REQ-015 Fetches from non-IMEM regions SHALL return 0.
REQ-016 A request dropped mid-access SHALL still complete; the response SHALL be ignored.

Reset
REQ-017 rst SHALL force IDLE immediately, clear wcnt and last-served, and zero all outputs; fault and fault_addr SHALL also clear.
REQ-018 Reset during ACCESS SHALL abort the access with no mem_we and no valid.

Configuration
REQ-019 With MEMCTRL_FAULT_EN defined, an unmapped access, a write to IMEM/ROM, or a fetch outside IMEM SHALL set fault and capture fault_addr on the first such event only.
REQ-020 Without MEMCTRL_FAULT_EN, fault and fault_addr SHALL be tied to 0 and no fault logic SHALL exist.

Verification
REQ-021 The bench SHALL cover:
- Fetch i_addr=8 -> i_valid 2 cycles later, mem_sel=1, mem_addr=8, i_rdata=imem_rdata.
- Data read d_addr=400 -> mem_sel=2, mem_addr=0, d_valid 3 cycles later.
- Write d_addr=8504, d_wdata=0xDEADBEEF -> one mem_we pulse, mem_addr=4, d_valid 4 cycles after request.
- Simultaneous i_req and d_req from reset -> data served first, then fetch; arbitration alternates thereafter.
- d_addr=200000 read -> d_rdata=0, no strobe; with MEMCTRL_FAULT_EN, fault=1 and fault_addr=200000, held across a second fault at 300000.
- rst asserted mid-RAM-write -> no mem_we, no valid, all outputs 0.
